// File: rtl/aemb_dwb_lsu.sv
// Load/store unit: registers an ALU memory request, runs one Wishbone data cycle,
// aligns returned load data for write-back and aborts a cycle that is never acknowledged.
module aemb_dwb_lsu #(
   parameter int unsigned DW  = 32,
   parameter int unsigned TMO = 15,
   parameter int unsigned TW  = 4
) (
   input  logic          gclk,
   input  logic          grst,
   input  logic          gena,
   input  logic          mem_req,
   input  logic          mem_we,
   input  logic [DW-1:2] mem_adr,
   input  logic [3:0]    mem_sel,
   input  logic [31:0]   mem_dat,
   input  logic [4:0]    mem_rd,
   output logic          dwb_stb_o,
   output logic          dwb_we_o,
   output logic [DW-1:2] dwb_adr_o,
   output logic [3:0]    dwb_sel_o,
   output logic [31:0]   dwb_dat_o,
   input  logic          dwb_ack_i,
   input  logic [31:0]   dwb_dat_i,
   output logic [31:0]   rDWBDI,
   output logic          rLDV,
   output logic [4:0]    rLDRD,
   output logic          lsu_stall,
   output logic          lsu_err
);

   typedef enum logic [0:0] {StIdle, StBus} state_e;

   // Counter value seen during the last BUS cycle allowed before an abort.
   localparam logic [TW-1:0] TmoLast = TW'((TMO == 0) ? 0 : TMO - 1);

   state_e          state_q, state_d;
   logic            stb_q, stb_d;
   logic            we_q, we_d;
   logic [DW-1:2]   adr_q, adr_d;
   logic [3:0]      sel_q, sel_d;
   logic [31:0]     dato_q, dato_d;
   logic [4:0]      prd_q, prd_d;
   logic [31:0]     dwbdi_q, dwbdi_d;
   logic            ldv_q, ldv_d;
   logic [4:0]      ldrd_q, ldrd_d;
   logic            err_q, err_d;
   logic [TW-1:0]   cnt_q, cnt_d;
   logic [31:0]     ld_align;
   logic [31:0]     st_repl;
   logic            tmo_hit;

   // Big-endian lane extraction with zero extension of narrow loads.
   always_comb begin
      ld_align = dwb_dat_i;
      unique case (sel_q)
         4'h8:    ld_align = {24'h0, dwb_dat_i[31:24]};
         4'h4:    ld_align = {24'h0, dwb_dat_i[23:16]};
         4'h2:    ld_align = {24'h0, dwb_dat_i[15:8]};
         4'h1:    ld_align = {24'h0, dwb_dat_i[7:0]};
         4'hC:    ld_align = {16'h0, dwb_dat_i[31:16]};
         4'h3:    ld_align = {16'h0, dwb_dat_i[15:0]};
         default: ld_align = dwb_dat_i;
      endcase
   end

   // Replicate store data across every lane the access could target.
   always_comb begin
      st_repl = mem_dat;
      unique case (mem_sel)
         4'h8, 4'h4, 4'h2, 4'h1: st_repl = {4{mem_dat[7:0]}};
         4'hC, 4'h3:             st_repl = {2{mem_dat[15:0]}};
         default:                st_repl = mem_dat;
      endcase
   end

   assign tmo_hit = (TMO != 0) && (cnt_q == TmoLast);

   // Next-state: accept requests in IDLE, finish or abort the bus cycle in BUS.
   always_comb begin
      state_d = state_q;
      stb_d   = stb_q;
      we_d    = we_q;
      adr_d   = adr_q;
      sel_d   = sel_q;
      dato_d  = dato_q;
      prd_d   = prd_q;
      dwbdi_d = dwbdi_q;
      ldv_d   = 1'b0;
      ldrd_d  = ldrd_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (gena && mem_req) begin
               state_d = StBus;
               stb_d   = 1'b1;
               we_d    = mem_we;
               adr_d   = mem_adr;
               sel_d   = mem_sel;
               dato_d  = st_repl;
               prd_d   = mem_rd;
               cnt_d   = '0;
            end
         end
         StBus: begin
            if (dwb_ack_i) begin
               // An ack on the timeout cycle still completes normally.
               state_d = StIdle;
               stb_d   = 1'b0;
               if (!we_q) begin
                  dwbdi_d = ld_align;
                  ldrd_d  = prd_q;
                  ldv_d   = 1'b1;
               end
            end else if (tmo_hit) begin
               state_d = StIdle;
               stb_d   = 1'b0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge gclk) begin
      if (grst) begin
         state_q <= StIdle;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         sel_q   <= '0;
         dato_q  <= '0;
         prd_q   <= '0;
         dwbdi_q <= '0;
         ldv_q   <= 1'b0;
         ldrd_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         dato_q  <= dato_d;
         prd_q   <= prd_d;
         dwbdi_q <= dwbdi_d;
         ldv_q   <= ldv_d;
         ldrd_q  <= ldrd_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dwb_stb_o = stb_q;
   assign dwb_we_o  = we_q;
   assign dwb_adr_o = adr_q;
   assign dwb_sel_o = sel_q;
   assign dwb_dat_o = dato_q;
   assign rDWBDI    = dwbdi_q;
   assign rLDV      = ldv_q;
   assign rLDRD     = ldrd_q;
   assign lsu_err   = err_q;
   assign lsu_stall = (state_q == StBus) && !dwb_ack_i;

endmodule

// File: tb/tb_aemb_dwb_lsu.sv
// Bench for aemb_dwb_lsu: directed scenarios followed by randomized transactions
// checked against a lane-arithmetic reference model.
module tb_aemb_dwb_lsu;

   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 15;
   localparam int unsigned TW  = 4;

   logic          gclk = 1'b0;
   logic          grst;
   logic          gena;
   logic          mem_req;
   logic          mem_we;
   logic [DW-1:2] mem_adr;
   logic [3:0]    mem_sel;
   logic [31:0]   mem_dat;
   logic [4:0]    mem_rd;
   logic          dwb_stb_o;
   logic          dwb_we_o;
   logic [DW-1:2] dwb_adr_o;
   logic [3:0]    dwb_sel_o;
   logic [31:0]   dwb_dat_o;
   logic          dwb_ack_i;
   logic [31:0]   dwb_dat_i;
   logic [31:0]   rDWBDI;
   logic          rLDV;
   logic [4:0]    rLDRD;
   logic          lsu_stall;
   logic          lsu_err;

   aemb_dwb_lsu #(
      .DW  (DW),
      .TMO (TMO),
      .TW  (TW)
   ) dut (
      .gclk      (gclk),
      .grst      (grst),
      .gena      (gena),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_adr   (mem_adr),
      .mem_sel   (mem_sel),
      .mem_dat   (mem_dat),
      .mem_rd    (mem_rd),
      .dwb_stb_o (dwb_stb_o),
      .dwb_we_o  (dwb_we_o),
      .dwb_adr_o (dwb_adr_o),
      .dwb_sel_o (dwb_sel_o),
      .dwb_dat_o (dwb_dat_o),
      .dwb_ack_i (dwb_ack_i),
      .dwb_dat_i (dwb_dat_i),
      .rDWBDI    (rDWBDI),
      .rLDV      (rLDV),
      .rLDRD     (rLDRD),
      .lsu_stall (lsu_stall),
      .lsu_err   (lsu_err)
   );

   always #5 gclk = ~gclk;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned n_fail = 0;

   // Reference state: last completed load result and destination.
   logic [31:0] exp_dwbdi;
   logic [4:0]  exp_ldrd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge gclk);
      #1;
   endtask

   // Big-endian: lane k of a one-hot select holds bits [8k+7:8k].
   function automatic logic [31:0] ref_align(input logic [3:0] sel, input logic [31:0] d);
      for (int k = 0; k < 4; k++)
         if (sel == 4'(1 << k)) return (d >> (8 * k)) & 32'hFF;
      if (sel == 4'hC) return d >> 16;
      if (sel == 4'h3) return d & 32'hFFFF;
      return d;
   endfunction

   function automatic logic [31:0] ref_repl(input logic [3:0] sel, input logic [31:0] d);
      if (sel == 4'h8 || sel == 4'h4 || sel == 4'h2 || sel == 4'h1)
         return (d & 32'hFF) * 32'h01010101;
      if (sel == 4'hC || sel == 4'h3)
         return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   task automatic check_quiet(input string tag);
      chk({tag, "_stb"}, dwb_stb_o, 0);
      chk({tag, "_ldv"}, rLDV, 0);
      chk({tag, "_err"}, lsu_err, 0);
      chk({tag, "_stall"}, lsu_stall, 0);
   endtask

   // One request; dly = BUS cycles without ack before ack (dly >= TMO means never acked).
   task automatic txn(input logic we, input logic [DW-1:2] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input logic [4:0] rd, input int dly,
                      input logic [31:0] rdat);
      logic [31:0] exp_dato;
      exp_dato = ref_repl(sel, dat);
      gena    = 1'b1;
      mem_req = 1'b1;
      mem_we  = we;
      mem_adr = adr;
      mem_sel = sel;
      mem_dat = dat;
      mem_rd  = rd;
      chk("pre_stb", dwb_stb_o, 0);
      step();
      mem_req = 1'b0;
      for (int i = 0; i < dly && i < int'(TMO); i++) begin
         dwb_dat_i = $urandom;
         chk("bus_stb", dwb_stb_o, 1);
         chk("bus_we", dwb_we_o, we);
         chk("bus_adr", dwb_adr_o, adr);
         chk("bus_sel", dwb_sel_o, sel);
         chk("bus_dat", dwb_dat_o, exp_dato);
         chk("bus_stall", lsu_stall, 1);
         step();
      end
      if (dly < int'(TMO)) begin
         dwb_ack_i = 1'b1;
         dwb_dat_i = rdat;
         #1;
         chk("ack_stb", dwb_stb_o, 1);
         chk("ack_dat", dwb_dat_o, exp_dato);
         chk("ack_stall", lsu_stall, 0);
         step();
         dwb_ack_i = 1'b0;
         dwb_dat_i = $urandom;
         if (!we) begin
            exp_dwbdi = ref_align(sel, rdat);
            exp_ldrd  = rd;
         end
         chk("done_stb", dwb_stb_o, 0);
         chk("done_ldv", rLDV, !we);
         chk("done_dwbdi", rDWBDI, exp_dwbdi);
         chk("done_ldrd", rLDRD, exp_ldrd);
         chk("done_err", lsu_err, 0);
         chk("done_stall", lsu_stall, 0);
         step();
         chk("post_ldv", rLDV, 0);
      end else begin
         chk("tmo_stb", dwb_stb_o, 0);
         chk("tmo_err", lsu_err, 1);
         chk("tmo_ldv", rLDV, 0);
         chk("tmo_dwbdi", rDWBDI, exp_dwbdi);
         chk("tmo_stall", lsu_stall, 0);
         step();
         chk("tmo_err_pulse", lsu_err, 0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_stb"}, dwb_stb_o, 0);
      chk({tag, "_we"}, dwb_we_o, 0);
      chk({tag, "_adr"}, dwb_adr_o, 0);
      chk({tag, "_sel"}, dwb_sel_o, 0);
      chk({tag, "_dato"}, dwb_dat_o, 0);
      chk({tag, "_dwbdi"}, rDWBDI, 0);
      chk({tag, "_ldv"}, rLDV, 0);
      chk({tag, "_ldrd"}, rLDRD, 0);
      chk({tag, "_stall"}, lsu_stall, 0);
      chk({tag, "_err"}, lsu_err, 0);
   endtask

   initial begin
      logic [3:0] sel_tab [8];
      logic [3:0] s;
      int         r;
      int         dly;
      sel_tab = '{4'h8, 4'h4, 4'h2, 4'h1, 4'hC, 4'h3, 4'hF, 4'h0};
      grst      = 1'b1;
      gena      = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_adr   = '0;
      mem_sel   = '0;
      mem_dat   = '0;
      mem_rd    = '0;
      dwb_ack_i = 1'b0;
      dwb_dat_i = '0;
      exp_dwbdi = '0;
      exp_ldrd  = '0;
      step();
      step();
      check_all_zero("reset");
      grst = 1'b0;
      step();

      // Byte load, ack in first BUS cycle.
      txn(1'b0, 30'(32'h100 >> 2), 4'h8, 32'h0, 5'd7, 0, 32'hA1B2C3D4);
      // Half store, replicated data.
      txn(1'b1, 30'h0000_0123, 4'h3, 32'h0000BEEF, 5'd9, 2, 32'h0);
      // Word load with five wait states.
      txn(1'b0, 30'h0000_0040, 4'hF, 32'h0, 5'd3, 5, 32'hCAFEF00D);
      // Timeout: no ack at all; rDWBDI must keep the previous load.
      txn(1'b0, 30'h0000_0055, 4'h4, 32'h0, 5'd12, int'(TMO), 32'h0);
      // Ack on the abort cycle completes normally.
      txn(1'b0, 30'h0000_0056, 4'hC, 32'h0, 5'd13, int'(TMO) - 1, 32'h89AB4567);

      // Reset in the middle of a wait.
      gena    = 1'b1;
      mem_req = 1'b1;
      mem_we  = 1'b0;
      mem_adr = 30'h3;
      mem_sel = 4'h1;
      mem_rd  = 5'd21;
      step();
      mem_req = 1'b0;
      step();
      chk("rst_pre_stb", dwb_stb_o, 1);
      grst = 1'b1;
      step();
      check_all_zero("rst_mid");
      grst = 1'b0;
      exp_dwbdi = '0;
      exp_ldrd  = '0;
      dwb_ack_i = 1'b1;
      dwb_dat_i = 32'hFFFFFFFF;
      step();
      dwb_ack_i = 1'b0;
      check_all_zero("rst_late_ack");
      txn(1'b0, 30'h0000_0007, 4'h1, 32'h0, 5'd22, 1, 32'h11223344);

      // Spurious ack in IDLE, and a request with gena low.
      dwb_ack_i = 1'b1;
      dwb_dat_i = 32'h55555555;
      step();
      dwb_ack_i = 1'b0;
      check_quiet("spur");
      chk("spur_dwbdi", rDWBDI, exp_dwbdi);
      gena    = 1'b0;
      mem_req = 1'b1;
      step();
      check_quiet("gena0_a");
      step();
      check_quiet("gena0_b");
      mem_req = 1'b0;

      // Randomized transactions.
      for (int n = 0; n < 60; n++) begin
         s = sel_tab[$urandom_range(0, 7)];
         if (s == 4'h0) s = 4'($urandom);
         r = int'($urandom_range(0, 9));
         dly = (r == 9) ? int'(TMO) : (r == 8) ? int'(TMO) - 1 : r;
         txn(1'($urandom), 30'($urandom), s, $urandom, 5'($urandom), dly, $urandom);
         if ($urandom_range(0, 1) == 1) begin
            dwb_ack_i = 1'($urandom);
            step();
            dwb_ack_i = 1'b0;
            check_quiet("rnd_gap");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
